// File: rtl/ex_mem_pipe.sv
// Execute-to-memory pipeline register built as a two-entry skid buffer.
// Misaligned loads and stores are flagged on entry. They are presented downstream as NOP,
// so the memory stage never performs a spurious access.
module ex_mem_pipe #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_alu,
   input  logic [31:0]      in_rs2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [31:0]      out_pc,
   output logic [31:0]      out_alu,
   output logic [31:0]      out_rs2,
   output logic             out_misalign,
   output logic [CNT_W-1:0] cnt_fire,
   output logic [CNT_W-1:0] cnt_misalign
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t r_state;
   state_t w_state_d;

   logic [31:0] r_head_instr, r_head_pc, r_head_alu, r_head_rs2;
   logic        r_head_mis;
   logic [31:0] r_skid_instr, r_skid_pc, r_skid_alu, r_skid_rs2;
   logic        r_skid_mis;
   logic [CNT_W-1:0] r_cnt_fire, r_cnt_mis;

   logic w_in_fire, w_out_fire, w_out_valid, w_in_mis;
   logic w_load_head, w_load_skid, w_skid_to_head;

   // in_ready depends only on the state register, so out_ready has no combinational path to it.
   assign in_ready    = (r_state != StFull);
   assign w_out_valid = (r_state != StEmpty);
   assign w_in_fire   = in_valid & in_ready & ~flush;
   assign w_out_fire  = w_out_valid & out_ready;

   // Classify the incoming bundle: halfword and word loads/stores need natural alignment.
   always_comb begin
      w_in_mis = 1'b0;
      case ({in_instr[14:12], in_instr[6:0]})
         10'b001_0000011, 10'b101_0000011, 10'b001_0100011: w_in_mis = in_alu[0];
         10'b010_0000011, 10'b010_0100011:                  w_in_mis = |in_alu[1:0];
         default:                                           w_in_mis = 1'b0;
      endcase
   end

   // Next-state and entry-move decode; flush overrides everything to EMPTY.
   always_comb begin
      w_state_d      = r_state;
      w_load_head    = 1'b0;
      w_load_skid    = 1'b0;
      w_skid_to_head = 1'b0;
      case (r_state)
         StEmpty: begin
            if (w_in_fire) begin
               w_state_d   = StOne;
               w_load_head = 1'b1;
            end
         end
         StOne: begin
            if (w_in_fire && w_out_fire) begin
               w_load_head = 1'b1;
            end else if (w_in_fire) begin
               w_state_d   = StFull;
               w_load_skid = 1'b1;
            end else if (w_out_fire) begin
               w_state_d = StEmpty;
            end
         end
         StFull: begin
            if (w_out_fire) begin
               w_state_d      = StOne;
               w_skid_to_head = 1'b1;
            end
         end
         default: w_state_d = StEmpty;
      endcase
      if (flush) begin
         w_state_d = StEmpty;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StEmpty;
      end else begin
         r_state <= w_state_d;
      end
   end

   // HEAD entry: loaded from the input, or promoted from SKID when FULL drains.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head_instr <= '0;
         r_head_pc    <= '0;
         r_head_alu   <= '0;
         r_head_rs2   <= '0;
         r_head_mis   <= 1'b0;
      end else if (w_load_head) begin
         r_head_instr <= in_instr;
         r_head_pc    <= in_pc;
         r_head_alu   <= in_alu;
         r_head_rs2   <= in_rs2;
         r_head_mis   <= w_in_mis;
      end else if (w_skid_to_head) begin
         r_head_instr <= r_skid_instr;
         r_head_pc    <= r_skid_pc;
         r_head_alu   <= r_skid_alu;
         r_head_rs2   <= r_skid_rs2;
         r_head_mis   <= r_skid_mis;
      end
   end

   // SKID entry: absorbs the bundle accepted while HEAD is stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_skid_instr <= '0;
         r_skid_pc    <= '0;
         r_skid_alu   <= '0;
         r_skid_rs2   <= '0;
         r_skid_mis   <= 1'b0;
      end else if (w_load_skid) begin
         r_skid_instr <= in_instr;
         r_skid_pc    <= in_pc;
         r_skid_alu   <= in_alu;
         r_skid_rs2   <= in_rs2;
         r_skid_mis   <= w_in_mis;
      end
   end

   // Performance counters: count completed transfers, including the one in a flush cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt_fire <= '0;
         r_cnt_mis  <= '0;
      end else if (w_out_fire) begin
         r_cnt_fire <= r_cnt_fire + CntOne;
         if (r_head_mis) begin
            r_cnt_mis <= r_cnt_mis + CntOne;
         end
      end
   end

   // Output steering: bubbles show NOP and zeros; a misaligned head keeps its fields for trap
   // reporting but shows NOP as the instruction.
   always_comb begin
      out_valid    = w_out_valid;
      out_instr    = NOP_INSTR;
      out_pc       = '0;
      out_alu      = '0;
      out_rs2      = '0;
      out_misalign = 1'b0;
      if (w_out_valid) begin
         out_instr    = r_head_mis ? NOP_INSTR : r_head_instr;
         out_pc       = r_head_pc;
         out_alu      = r_head_alu;
         out_rs2      = r_head_rs2;
         out_misalign = r_head_mis;
      end
   end

   assign cnt_fire     = r_cnt_fire;
   assign cnt_misalign = r_cnt_mis;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe with a scoreboard queue of expected bundles.
module tb_ex_mem_pipe;

   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] rs2;
      logic        mis;
   } bundle_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0, in_pc = '0, in_alu = '0, in_rs2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr, out_pc, out_alu, out_rs2;
   logic        out_misalign;
   logic [31:0] cnt_fire, cnt_misalign;

   bundle_t     q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] m_fire = '0;
   logic [31:0] m_mis = '0;
   logic        in_acc;

   ex_mem_pipe #(.NOP_INSTR(NOP), .CNT_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .in_alu       (in_alu),
      .in_rs2       (in_rs2),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .out_alu      (out_alu),
      .out_rs2      (out_rs2),
      .out_misalign (out_misalign),
      .cnt_fire     (cnt_fire),
      .cnt_misalign (cnt_misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass,
               n_checks);
      $fatal(1, "watchdog expired");
   end

   function automatic logic model_mis(logic [31:0] instr, logic [31:0] alu);
      case ({instr[14:12], instr[6:0]})
         {3'b001, 7'h03}, {3'b101, 7'h03}, {3'b001, 7'h23}: return alu[0];
         {3'b010, 7'h03}, {3'b010, 7'h23}:                  return alu[1:0] != 2'b00;
         default:                                           return 1'b0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One clock: check outputs against the model on the falling edge, then advance the model.
   task automatic tick();
      bundle_t h;
      bit      can_acc;
      @(negedge clk);
      can_acc = (q.size() < 2);
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, can_acc});
      chk("cnt_fire", cnt_fire, m_fire);
      chk("cnt_misalign", cnt_misalign, m_mis);
      if (q.size() != 0) begin
         h = q[0];
         chk("out_instr", out_instr, h.mis ? NOP : h.instr);
         chk("out_pc", out_pc, h.pc);
         chk("out_alu", out_alu, h.alu);
         chk("out_rs2", out_rs2, h.rs2);
         chk("out_misalign", {31'd0, out_misalign}, {31'd0, h.mis});
         if (out_ready) begin
            void'(q.pop_front());
            m_fire = m_fire + 32'd1;
            if (h.mis) m_mis = m_mis + 32'd1;
         end
      end else begin
         chk("idle_instr", out_instr, NOP);
         chk("idle_pc", out_pc, 32'd0);
         chk("idle_alu", out_alu, 32'd0);
         chk("idle_rs2", out_rs2, 32'd0);
         chk("idle_misalign", {31'd0, out_misalign}, 32'd0);
      end
      in_acc = 1'b0;
      if (flush) begin
         q.delete();
      end else if (in_valid && can_acc) begin
         in_acc = 1'b1;
         q.push_back('{instr: in_instr, pc: in_pc, alu: in_alu, rs2: in_rs2,
                       mis: model_mis(in_instr, in_alu)});
      end
      @(posedge clk);
      #1;
   endtask

   // Present a bundle until the model says it was accepted (bounded).
   task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rs2);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      in_alu   = alu;
      in_rs2   = rs2;
      in_acc   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (in_acc) break;
      end
      chk("send_accepted", {31'd0, in_acc}, 32'd1);
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_instr", out_instr, NOP);
      chk("rst_cnt_fire", cnt_fire, 32'd0);
      #10 rst = 1'b1;
      @(posedge clk);
      #1;
      tick();

      // Single lw, then drain
      out_ready = 1'b1;
      send(32'h0000A103, 32'h80000000, 32'h00000100, 32'h0);
      tick();
      tick();

      // Stream of 8 at full throughput
      for (int i = 0; i < 8; i++) begin
         send(32'h00002083 | (i << 7), 32'h80000100 + i * 4, 32'h200 + i * 4, 32'hA0 + i);
      end
      tick();
      tick();
      chk("stream_cnt", cnt_fire, 32'd9);

      // Backpressure: A, B accepted, C stalls until drain
      out_ready = 1'b0;
      send(32'h00002183, 32'h1000, 32'h300, 32'h1);
      send(32'h00002203, 32'h1004, 32'h304, 32'h2);
      in_valid = 1'b1;
      in_instr = 32'h00002283;
      in_pc    = 32'h1008;
      in_alu   = 32'h308;
      in_rs2   = 32'h3;
      tick();
      tick();
      chk("bp_stalled", {31'd0, in_acc}, 32'd0);
      out_ready = 1'b1;
      send(32'h00002283, 32'h1008, 32'h308, 32'h3);
      tick();
      tick();

      // Misaligned sw squashed to NOP, sh at 0x102 aligned
      send(32'h00112023, 32'h2000, 32'h102, 32'hDEAD);
      send(32'h00111023, 32'h2004, 32'h102, 32'hBEEF);
      send(32'h00109083, 32'h2008, 32'h101, 32'h0);
      send(32'h00008083, 32'h200C, 32'h103, 32'h0);
      tick();
      tick();
      chk("mis_cnt", cnt_misalign, 32'd2);

      // Flush while FULL with a pending input
      out_ready = 1'b0;
      send(32'h00002303, 32'h3000, 32'h400, 32'h5);
      send(32'h00002383, 32'h3004, 32'h404, 32'h6);
      in_valid = 1'b1;
      in_instr = 32'h00002403;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      // Flush in ONE with out_fire: head counts, same-cycle input is dropped
      send(32'h00002483, 32'h3100, 32'h500, 32'h7);
      in_valid = 1'b1;
      in_instr = 32'h00002503;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      tick();
      tick();

      // Asynchronous reset between edges mid-stream
      out_ready = 1'b0;
      send(32'h00002583, 32'h4000, 32'h600, 32'h8);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_cnt_fire", cnt_fire, 32'd0);
      chk("arst_cnt_mis", cnt_misalign, 32'd0);
      chk("arst_out_instr", out_instr, NOP);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      q.delete();
      m_fire = '0;
      m_mis  = '0;
      tick();
      #2 rst = 1'b1;
      out_ready = 1'b1;
      send(32'h00002603, 32'h5000, 32'h700, 32'h9);
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
